// File: rtl/cpu_mem_pkg.sv
// Shared CPU/data-memory definitions: bus width defaults, responder states
// and the load/store opcodes decoded on the CPU side.
package cpu_mem_pkg;

    localparam int CPU_DATA_W = 16;
    localparam int CPU_ADDR_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } dmem_state_t;

    localparam logic [3:0] OP_STUR = 4'he;
    localparam logic [3:0] OP_LDUR = 4'hf;

endpackage

// File: rtl/dmem_responder_if.sv
// Request/response channels between the CPU and the data memory.
// rsp_err is present only when DMEM_ERR_EN is defined.
interface dmem_responder_if
    import cpu_mem_pkg::*;
#(
    parameter int DATA_W = CPU_DATA_W,
    parameter int ADDR_W = CPU_ADDR_W
);

    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_rdata;
`ifdef DMEM_ERR_EN
    logic              rsp_err;

    modport master (
        output req_valid, req_we, req_addr, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );
    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
`else
    modport master (
        output req_valid, req_we, req_addr, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata
    );
    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata
    );
`endif

endinterface

// File: rtl/dmem_array.sv
// DEPTH x DATA_W word storage: synchronous write, combinational read,
// asynchronous clear; addresses at or beyond DEPTH read 0 and never write.
module dmem_array #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 4,
    parameter int DEPTH  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [DATA_W-1:0] i_wdata,
    output logic [DATA_W-1:0] o_rdata,
    output logic              o_in_range
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [IDX_W-1:0]  w_idx;

    assign o_in_range = (32'(i_addr) < 32'(DEPTH));
    assign w_idx      = i_addr[IDX_W-1:0];
    assign o_rdata    = o_in_range ? r_mem[w_idx] : {DATA_W{1'b0}};

    // Word storage with asynchronous clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= {DATA_W{1'b0}};
            end
        end else if (i_we && o_in_range) begin
            r_mem[w_idx] <= i_wdata;
        end
    end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: one request at a time, WAIT_CYCLES wait states,
// response held until consumed. Define DMEM_ERR_EN for the rsp_err flag.
module dmem_responder
    import cpu_mem_pkg::*;
#(
    parameter int DATA_W      = CPU_DATA_W,
    parameter int ADDR_W      = CPU_ADDR_W,
    parameter int DEPTH       = 16,
    parameter int WAIT_CYCLES = 0
) (
    input  logic             clk,
    input  logic             rst,
    dmem_responder_if.slave  bus
);

    localparam int CNT_W = 4;

    dmem_state_t       r_state;
    dmem_state_t       w_next;
    logic [CNT_W-1:0]  r_cnt;
    logic [CNT_W-1:0]  w_cnt_next;
    logic              r_we;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic [DATA_W-1:0] r_rdata;
    logic              r_req_ready;
    logic              r_rsp_valid;
    logic              w_accept;
    logic              w_commit;
    logic              w_op_we;
    logic [ADDR_W-1:0] w_op_addr;
    logic [DATA_W-1:0] w_op_wdata;
    logic [DATA_W-1:0] w_arr_rdata;
    logic              w_in_range;

    // With zero wait states the commit edge is the accept edge, so the
    // operation comes straight from the bus while still in IDLE.
    assign w_accept   = (r_state == IDLE) && bus.req_valid;
    assign w_commit   = (r_state != RESP) && (w_next == RESP);
    assign w_op_we    = (r_state == IDLE) ? bus.req_we    : r_we;
    assign w_op_addr  = (r_state == IDLE) ? bus.req_addr  : r_addr;
    assign w_op_wdata = (r_state == IDLE) ? bus.req_wdata : r_wdata;

    dmem_array #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) u_array (
        .clk        (clk),
        .rst        (rst),
        .i_we       (w_commit && w_op_we && w_in_range),
        .i_addr     (w_op_addr),
        .i_wdata    (w_op_wdata),
        .o_rdata    (w_arr_rdata),
        .o_in_range (w_in_range)
    );

    // Next-state and wait-counter logic.
    always_comb begin
        w_next     = r_state;
        w_cnt_next = r_cnt;
        case (r_state)
            IDLE: begin
                if (bus.req_valid) begin
                    if (WAIT_CYCLES == 0) begin
                        w_next = RESP;
                    end else begin
                        w_next     = WAIT;
                        w_cnt_next = CNT_W'(WAIT_CYCLES - 1);
                    end
                end else begin
                    w_next = IDLE;
                end
            end
            WAIT: begin
                if (r_cnt == {CNT_W{1'b0}}) begin
                    w_next = RESP;
                end else begin
                    w_cnt_next = r_cnt - 4'd1;
                end
            end
            RESP: begin
                if (bus.rsp_ready) begin
                    w_next = IDLE;
                end else begin
                    w_next = RESP;
                end
            end
            default: begin
                w_next     = IDLE;
                w_cnt_next = {CNT_W{1'b0}};
            end
        endcase
    end

    // State, request capture and registered handshake/response outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_cnt       <= {CNT_W{1'b0}};
            r_we        <= 1'b0;
            r_addr      <= {ADDR_W{1'b0}};
            r_wdata     <= {DATA_W{1'b0}};
            r_rdata     <= {DATA_W{1'b0}};
            r_req_ready <= 1'b1;
            r_rsp_valid <= 1'b0;
        end else begin
            r_state     <= w_next;
            r_cnt       <= w_cnt_next;
            r_req_ready <= (w_next == IDLE);
            r_rsp_valid <= (w_next == RESP);
            if (w_accept) begin
                r_we    <= bus.req_we;
                r_addr  <= bus.req_addr;
                r_wdata <= bus.req_wdata;
            end
            if (w_commit) begin
                r_rdata <= w_op_we ? {DATA_W{1'b0}} : w_arr_rdata;
            end
        end
    end

    assign bus.req_ready = r_req_ready;
    assign bus.rsp_valid = r_rsp_valid;
    assign bus.rsp_rdata = r_rdata;

`ifdef DMEM_ERR_EN
    logic r_err;

    // Out-of-range flag, set at commit and dropped with rsp_valid.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_err <= 1'b0;
        end else if (w_commit) begin
            r_err <= !w_in_range;
        end else if (w_next == IDLE) begin
            r_err <= 1'b0;
        end
    end

    assign bus.rsp_err = r_err;
`endif

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: three instances (0, 3 and 1 wait states,
// the last with DEPTH=8) driven through their own interfaces.
module tb_dmem_responder;

`ifdef DMEM_ERR_EN
    localparam logic ERR_ON = 1'b1;
`else
    localparam logic ERR_ON = 1'b0;
`endif

    logic        clk;
    logic [2:0]  rst;
    logic [2:0]  req_valid;
    logic [2:0]  req_we;
    logic [2:0]  rsp_ready;
    logic [3:0]  req_addr  [3];
    logic [15:0] req_wdata [3];
    wire  [2:0]  req_ready_w;
    wire  [2:0]  rsp_valid_w;
    wire  [2:0]  rsp_err_w;
    wire  [15:0] rsp_rdata_w [3];

    int n_checks = 0;
    int n_fail   = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int WC = (g == 0) ? 0 : ((g == 1) ? 3 : 1);
        localparam int DP = (g == 2) ? 8 : 16;

        dmem_responder_if #(.DATA_W(16), .ADDR_W(4)) bus ();

        assign bus.req_valid   = req_valid[g];
        assign bus.req_we      = req_we[g];
        assign bus.req_addr    = req_addr[g];
        assign bus.req_wdata   = req_wdata[g];
        assign bus.rsp_ready   = rsp_ready[g];
        assign req_ready_w[g]  = bus.req_ready;
        assign rsp_valid_w[g]  = bus.rsp_valid;
        assign rsp_rdata_w[g]  = bus.rsp_rdata;
`ifdef DMEM_ERR_EN
        assign rsp_err_w[g]    = bus.rsp_err;
`else
        assign rsp_err_w[g]    = 1'b0;
`endif

        dmem_responder #(
            .DATA_W      (16),
            .ADDR_W      (4),
            .DEPTH       (DP),
            .WAIT_CYCLES (WC)
        ) u_dut (
            .clk (clk),
            .rst (rst[g]),
            .bus (bus)
        );
    end

    function automatic int wc_of(input int k);
        return (k == 0) ? 0 : ((k == 1) ? 3 : 1);
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // One transaction on instance k. lat counts edges from the accepting edge
    // (which is edge 1) up to the edge after which rsp_valid is seen high.
    // With rsp_ready low the task returns while the response is still pending.
    task automatic xact(input int k, input logic we, input logic [3:0] addr,
                        input logic [15:0] wd, output logic [15:0] rd,
                        output logic err, output int lat, output time t_acc);
        int guard;
        @(negedge clk);
        req_valid[k] = 1'b1;
        req_we[k]    = we;
        req_addr[k]  = addr;
        req_wdata[k] = wd;
        guard = 0;
        while (!req_ready_w[k] && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        check_eq("accept_bound", {31'd0, req_ready_w[k]}, 32'd1);
        @(posedge clk);
        t_acc = $time;
        #1;
        req_valid[k] = 1'b0;
        lat = 1;
        while (!rsp_valid_w[k] && lat < 50) begin
            @(posedge clk);
            #1;
            lat++;
        end
        rd  = rsp_rdata_w[k];
        err = rsp_err_w[k];
        if (rsp_ready[k]) begin
            @(posedge clk);
            #1;
        end
    endtask

    logic [15:0] rd;
    logic        err;
    int          lat;
    time         t_acc;
    time         t_prev;

    initial begin
        rst       = 3'b000;
        req_valid = 3'b000;
        req_we    = 3'b000;
        rsp_ready = 3'b111;
        for (int i = 0; i < 3; i++) begin
            req_addr[i]  = 4'd0;
            req_wdata[i] = 16'd0;
        end
        #1;
        rst = 3'b111;
        #2;
        for (int k = 0; k < 3; k++) begin
            check_eq("rst_req_ready", {31'd0, req_ready_w[k]}, 32'd1);
            check_eq("rst_rsp_valid", {31'd0, rsp_valid_w[k]}, 32'd0);
            check_eq("rst_rsp_rdata", {16'd0, rsp_rdata_w[k]}, 32'd0);
            check_eq("rst_rsp_err",   {31'd0, rsp_err_w[k]},   32'd0);
        end
        @(negedge clk);
        rst = 3'b000;

        // Zero wait states: write then read back.
        xact(0, 1'b1, 4'd3, 16'h1234, rd, err, lat, t_acc);
        check_eq("w0_wr_lat",   32'(lat), 32'd1);
        check_eq("w0_wr_rdata", {16'd0, rd}, 32'd0);
        xact(0, 1'b0, 4'd3, 16'h0000, rd, err, lat, t_acc);
        check_eq("w0_rd_lat",   32'(lat), 32'd1);
        check_eq("w0_rd_rdata", {16'd0, rd}, 32'h1234);

        // Three wait states.
        xact(1, 1'b1, 4'd5, 16'h00FF, rd, err, lat, t_acc);
        check_eq("w3_wr_lat",   32'(lat), 32'd4);
        check_eq("w3_wr_rdata", {16'd0, rd}, 32'd0);
        xact(1, 1'b0, 4'd5, 16'h0000, rd, err, lat, t_acc);
        check_eq("w3_rd_lat",   32'(lat), 32'd4);
        check_eq("w3_rd_rdata", {16'd0, rd}, 32'h00FF);

        // Backpressure: response held, stray write requests ignored.
        xact(1, 1'b1, 4'd7, 16'h5A5A, rd, err, lat, t_acc);
        rsp_ready[1] = 1'b0;
        xact(1, 1'b0, 4'd7, 16'h0000, rd, err, lat, t_acc);
        check_eq("bp_first_rdata", {16'd0, rd}, 32'h5A5A);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            req_valid[1] = (i % 2 == 0);
            req_we[1]    = 1'b1;
            req_addr[1]  = 4'd7;
            req_wdata[1] = 16'hDEAD;
            @(posedge clk);
            #1;
            check_eq("bp_hold_valid", {31'd0, rsp_valid_w[1]}, 32'd1);
            check_eq("bp_hold_rdata", {16'd0, rsp_rdata_w[1]}, 32'h5A5A);
            check_eq("bp_hold_ready", {31'd0, req_ready_w[1]}, 32'd0);
        end
        @(negedge clk);
        req_valid[1] = 1'b0;
        rsp_ready[1] = 1'b1;
        @(posedge clk);
        #1;
        check_eq("bp_done_valid", {31'd0, rsp_valid_w[1]}, 32'd0);
        check_eq("bp_done_ready", {31'd0, req_ready_w[1]}, 32'd1);
        xact(1, 1'b0, 4'd7, 16'h0000, rd, err, lat, t_acc);
        check_eq("bp_after_rdata", {16'd0, rd}, 32'h5A5A);

        // Reset while a write waits to commit.
        xact(1, 1'b1, 4'd2, 16'h1111, rd, err, lat, t_acc);
        xact(1, 1'b0, 4'd2, 16'h0000, rd, err, lat, t_acc);
        check_eq("rs_pre_rdata", {16'd0, rd}, 32'h1111);
        @(negedge clk);
        req_valid[1] = 1'b1;
        req_we[1]    = 1'b1;
        req_addr[1]  = 4'd2;
        req_wdata[1] = 16'hBEEF;
        @(posedge clk);
        #1;
        req_valid[1] = 1'b0;
        check_eq("rs_in_wait_ready", {31'd0, req_ready_w[1]}, 32'd0);
        #2;
        rst[1] = 1'b1;
        #1;
        check_eq("rs_async_ready", {31'd0, req_ready_w[1]}, 32'd1);
        check_eq("rs_async_valid", {31'd0, rsp_valid_w[1]}, 32'd0);
        check_eq("rs_async_rdata", {16'd0, rsp_rdata_w[1]}, 32'd0);
        @(negedge clk);
        rst[1] = 1'b0;
        xact(1, 1'b0, 4'd2, 16'h0000, rd, err, lat, t_acc);
        check_eq("rs_read_rdata", {16'd0, rd}, 32'd0);
        check_eq("rs_read_lat",   32'(lat), 32'd4);

        // DEPTH=8: out-of-range accesses.
        xact(2, 1'b1, 4'd4, 16'h4444, rd, err, lat, t_acc);
        check_eq("oor_w4_err", {31'd0, err}, 32'd0);
        check_eq("oor_w4_lat", 32'(lat), 32'd2);
        xact(2, 1'b1, 4'd12, 16'hAAAA, rd, err, lat, t_acc);
        check_eq("oor_w12_err",   {31'd0, err}, {31'd0, ERR_ON});
        check_eq("oor_w12_rdata", {16'd0, rd}, 32'd0);
        xact(2, 1'b0, 4'd12, 16'h0000, rd, err, lat, t_acc);
        check_eq("oor_r12_err",   {31'd0, err}, {31'd0, ERR_ON});
        check_eq("oor_r12_rdata", {16'd0, rd}, 32'd0);
        xact(2, 1'b0, 4'd4, 16'h0000, rd, err, lat, t_acc);
        check_eq("oor_r4_err",   {31'd0, err}, 32'd0);
        check_eq("oor_r4_rdata", {16'd0, rd}, 32'h4444);
        check_eq("oor_err_clr",  {31'd0, rsp_err_w[2]}, 32'd0);

        // Back-to-back fill and read-back; spacing is WAIT_CYCLES+2 cycles.
        for (int k = 0; k < 2; k++) begin
            t_prev = 0;
            for (int i = 0; i < 32; i++) begin
                xact(k, (i < 16), 4'(i), 16'(i % 16), rd, err, lat, t_acc);
                if (i >= 16) begin
                    check_eq("b2b_rdata", {16'd0, rd}, 32'(i % 16));
                end
                if (i > 0) begin
                    check_eq("b2b_spacing", 32'((t_acc - t_prev) / 10), 32'(wc_of(k) + 2));
                end
                t_prev = t_acc;
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
